branch_target_predictor: RTL and testbench

Parametrised standalone branch target predictor for the fetch stage, replacing the single-bit taken-only BTP that is built into tag fetch. Direct-mapped table with per-entry saturating direction counters and a registered 1-cycle lookup. It has a read-modify-write-free update port driven from WB, and a sweep-based flush/initialisation state machine. Sits beside the icache tag stage; its outputs feed next-PC selection and the BTP info passed to ID.

---
 rtl/branch_target_predictor.sv | 192 +++++++++++++++++++
 tb/tb_branch_target_predictor.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Branch target predictor for the fetch stage: direct-mapped table of
// {valid, tag, target, saturating counter} with a registered 1-cycle lookup,
// a write-only update port from WB and a sweep FSM that invalidates the
// whole table after reset or on flush_req.
// Optional feature macro: BTP_STATS_EN (lookup/hit statistics counters).
module branch_target_predictor #(
    parameter int NUM_ENTRIES  = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int COUNTER_BITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_req,
    output logic                    busy,
    input  logic                    lookup_en,
    input  logic [ADDR_WIDTH-1:0]   lookup_pc,
    output logic                    pred_valid,
    output logic                    pred_hit,
    output logic                    pred_taken,
    output logic [ADDR_WIDTH-1:0]   pred_target,
    output logic [COUNTER_BITS-1:0] pred_counter,
    input  logic                    upd_en,
    input  logic [ADDR_WIDTH-1:0]   upd_pc,
    input  logic                    upd_taken,
    input  logic [ADDR_WIDTH-1:0]   upd_target,
    input  logic                    upd_hit,
    input  logic [COUNTER_BITS-1:0] upd_counter,
    output logic [31:0]             stat_lookups,
    output logic [31:0]             stat_hits
);

    localparam int IDX_BITS  = $clog2(NUM_ENTRIES);
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - 2;
    localparam int TGT_BITS  = ADDR_WIDTH - 2;
    localparam int META_BITS = 1 + TAG_BITS + COUNTER_BITS;

    localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;
    localparam logic [COUNTER_BITS-1:0] CNT_WEAK = COUNTER_BITS'(1 << (COUNTER_BITS - 1));

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    // The entry is one physical 1r1w RAM word split into two lanes sharing the
    // address: meta {valid, tag, counter} and target. The target lane has its
    // own write enable so a not-taken update can keep the stored target
    // without a read-modify-write.
    logic [META_BITS-1:0] r_meta_mem [NUM_ENTRIES];
    logic [TGT_BITS-1:0]  r_tgt_mem  [NUM_ENTRIES];

    logic [0:0]          r_state;
    logic [IDX_BITS-1:0] r_sweep_idx;

    logic                 r_pred_valid;
    logic [TAG_BITS-1:0]  r_lk_tag;
    logic [META_BITS-1:0] r_rd_meta;
    logic [TGT_BITS-1:0]  r_rd_tgt;

    logic [IDX_BITS-1:0]     w_lk_idx;
    logic [TAG_BITS-1:0]     w_lk_tag;
    logic [IDX_BITS-1:0]     w_up_idx;
    logic [TAG_BITS-1:0]     w_up_tag;
    logic                    w_busy;
    logic [COUNTER_BITS-1:0] w_cnt_inc;
    logic [COUNTER_BITS-1:0] w_cnt_dec;
    logic                    w_meta_we;
    logic                    w_tgt_we;
    logic [IDX_BITS-1:0]     w_wr_idx;
    logic [META_BITS-1:0]    w_meta_wdata;
    logic [TGT_BITS-1:0]     w_tgt_wdata;
    logic                    w_rd_valid;
    logic [TAG_BITS-1:0]     w_rd_tag;
    logic [COUNTER_BITS-1:0] w_rd_cnt;
    logic                    w_hit;
    logic                    w_unused;

    assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
    assign w_lk_tag = lookup_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign w_up_idx = upd_pc[IDX_BITS+1:2];
    assign w_up_tag = upd_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign w_busy   = (r_state == ST_SWEEP);
    assign busy     = w_busy;

    // Instruction alignment bits never reach the table.
    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign w_cnt_inc = (upd_counter == CNT_MAX) ? CNT_MAX : upd_counter + COUNTER_BITS'(1);
    assign w_cnt_dec = (upd_counter == '0) ? '0 : upd_counter - COUNTER_BITS'(1);

    // Choose this cycle's single table write: sweep invalidation, or a WB update.
    always_comb begin
        w_meta_we    = 1'b0;
        w_tgt_we     = 1'b0;
        w_wr_idx     = w_up_idx;
        w_meta_wdata = '0;
        w_tgt_wdata  = upd_target[ADDR_WIDTH-1:2];
        if (rst) begin
            if (w_busy) begin
                w_meta_we = 1'b1;
                w_wr_idx  = r_sweep_idx;
            end else if (upd_en && !flush_req) begin
                if (upd_taken) begin
                    w_meta_we    = 1'b1;
                    w_tgt_we     = 1'b1;
                    w_meta_wdata = {1'b1, w_up_tag, (upd_hit ? w_cnt_inc : CNT_WEAK)};
                end else if (upd_hit) begin
                    w_meta_we    = 1'b1;
                    w_meta_wdata = {1'b1, w_up_tag, w_cnt_dec};
                end
            end
        end
    end

    // Table write port (no reset on the RAM array itself).
    always_ff @(posedge clk) begin
        if (w_meta_we) begin
            r_meta_mem[w_wr_idx] <= w_meta_wdata;
        end
        if (w_tgt_we) begin
            r_tgt_mem[w_wr_idx] <= w_tgt_wdata;
        end
    end

    // Sweep FSM: reset or flush restarts at index 0; one index per cycle.
    always_ff @(posedge clk) begin
        if (!rst || flush_req) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
        end else if (r_state == ST_SWEEP) begin
            if (r_sweep_idx == IDX_BITS'(NUM_ENTRIES - 1)) begin
                r_state <= ST_IDLE;
            end
            r_sweep_idx <= r_sweep_idx + IDX_BITS'(1);
        end
    end

    // Registered lookup with per-lane bypass of a same-cycle write to the same index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pred_valid <= 1'b0;
            r_lk_tag     <= '0;
            r_rd_meta    <= '0;
            r_rd_tgt     <= '0;
        end else begin
            r_pred_valid <= lookup_en && !w_busy;
            if (lookup_en) begin
                r_lk_tag  <= w_lk_tag;
                r_rd_meta <= (w_meta_we && (w_wr_idx == w_lk_idx)) ? w_meta_wdata
                                                                  : r_meta_mem[w_lk_idx];
                r_rd_tgt  <= (w_tgt_we && (w_wr_idx == w_lk_idx)) ? w_tgt_wdata
                                                                 : r_tgt_mem[w_lk_idx];
            end
        end
    end

    assign w_rd_valid = r_rd_meta[META_BITS-1];
    assign w_rd_tag   = r_rd_meta[META_BITS-2 -: TAG_BITS];
    assign w_rd_cnt   = r_rd_meta[COUNTER_BITS-1:0];
    assign w_hit      = r_pred_valid && w_rd_valid && (w_rd_tag == r_lk_tag);

    assign pred_valid   = r_pred_valid;
    assign pred_hit     = w_hit;
    assign pred_taken   = w_hit && w_rd_cnt[COUNTER_BITS-1];
    assign pred_target  = {r_rd_tgt, 2'b00};
    assign pred_counter = w_rd_cnt;

`ifdef BTP_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_hits;

    // Count presented predictions and hits; a flush starts a fresh window.
    always_ff @(posedge clk) begin
        if (!rst || flush_req) begin
            r_stat_lookups <= '0;
            r_stat_hits    <= '0;
        end else begin
            if (r_pred_valid) begin
                r_stat_lookups <= r_stat_lookups + 32'd1;
            end
            if (w_hit) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
        end
    end

    assign stat_lookups = r_stat_lookups;
    assign stat_hits    = r_stat_hits;
`else
    assign stat_lookups = '0;
    assign stat_hits    = '0;
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor: directed vector table,
// hand-written sweep/flush/reset sequences and a randomized run against a
// table-level reference model.
module tb_branch_target_predictor;

    localparam int NUM   = 1024;
    localparam int AW    = 32;
    localparam int CB    = 2;
    localparam int IDXB  = $clog2(NUM);
    localparam int CMAX  = (1 << CB) - 1;
    localparam int CWEAK = 1 << (CB - 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_req;
    logic          busy;
    logic          lookup_en;
    logic [AW-1:0] lookup_pc;
    logic          pred_valid;
    logic          pred_hit;
    logic          pred_taken;
    logic [AW-1:0] pred_target;
    logic [CB-1:0] pred_counter;
    logic          upd_en;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic [AW-1:0] upd_target;
    logic          upd_hit;
    logic [CB-1:0] upd_counter;
    logic [31:0]   stat_lookups;
    logic [31:0]   stat_hits;

    always #5 clk = ~clk;

    branch_target_predictor #(
        .NUM_ENTRIES (NUM),
        .ADDR_WIDTH  (AW),
        .COUNTER_BITS(CB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_req   (flush_req),
        .busy        (busy),
        .lookup_en   (lookup_en),
        .lookup_pc   (lookup_pc),
        .pred_valid  (pred_valid),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pred_counter(pred_counter),
        .upd_en      (upd_en),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .upd_hit     (upd_hit),
        .upd_counter (upd_counter),
        .stat_lookups(stat_lookups),
        .stat_hits   (stat_hits)
    );

    typedef struct packed {
        logic        flush;
        logic        lk_en;
        logic [31:0] lk_pc;
        logic        up_en;
        logic [31:0] up_pc;
        logic        up_taken;
        logic [31:0] up_tgt;
        logic        up_hit;
        logic [3:0]  up_cnt;
    } stim_t;

    typedef struct packed {
        logic        busy;
        logic        valid;
        logic        hit;
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  cnt;
        logic [31:0] sl;
        logic [31:0] sh;
    } exp_t;

    typedef struct packed {
        stim_t       s;
        logic        e_valid;
        logic        e_hit;
        logic        e_taken;
        logic        chk_tc;
        logic [31:0] e_tgt;
        logic [3:0]  e_cnt;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the table as plain arrays plus a count of sweep cycles left.
    bit          m_valid [NUM];
    int unsigned m_tag   [NUM];
    int unsigned m_tgt   [NUM];
    int unsigned m_cnt   [NUM];
    int          m_rem;
    bit          m_pv;
    bit          m_ph;
    int unsigned m_sl;
    int unsigned m_sh;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % NUM);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return int'(pc >> (IDXB + 2));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    endtask

    task automatic model_reset();
        foreach (m_valid[k]) m_valid[k] = 1'b0;
        m_rem = NUM;
        m_pv  = 1'b0;
        m_ph  = 1'b0;
        m_sl  = 0;
        m_sh  = 0;
    endtask

    // Apply one cycle of stimulus, advance the model, and return what the DUT should show after the edge.
    task automatic drive(input stim_t s, output exp_t e);
        int          i;
        int unsigned c;
        bit          bpre;
        flush_req   = s.flush;
        lookup_en   = s.lk_en;
        lookup_pc   = s.lk_pc;
        upd_en      = s.up_en;
        upd_pc      = s.up_pc;
        upd_taken   = s.up_taken;
        upd_target  = s.up_tgt;
        upd_hit     = s.up_hit;
        upd_counter = s.up_cnt[CB-1:0];
        bpre = (m_rem > 0);
        c = int'(s.up_cnt);
        if (s.up_en && !bpre && !s.flush) begin
            i = idx_of(s.up_pc);
            if (s.up_taken) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(s.up_pc);
                m_tgt[i]   = s.up_tgt & 32'hFFFF_FFFC;
                m_cnt[i]   = s.up_hit ? ((c + 1 > CMAX) ? CMAX : c + 1) : CWEAK;
            end else if (s.up_hit) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = tag_of(s.up_pc);
                m_cnt[i]   = (c == 0) ? 0 : c - 1;
            end
        end
        e = '0;
        e.valid = s.lk_en && !bpre;
        if (e.valid) begin
            i = idx_of(s.lk_pc);
            e.hit   = m_valid[i] && (m_tag[i] == tag_of(s.lk_pc));
            e.taken = e.hit && (m_cnt[i] >= CWEAK);
            e.tgt   = m_tgt[i];
            e.cnt   = 4'(m_cnt[i]);
        end
        if (s.flush) begin
            m_sl = 0;
            m_sh = 0;
        end else begin
            m_sl += m_pv;
            m_sh += (m_pv && m_ph);
        end
        if (s.flush) begin
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_rem = NUM;
        end else if (m_rem > 0) begin
            m_rem--;
        end
        e.busy = (m_rem > 0);
        e.sl   = m_sl;
        e.sh   = m_sh;
        m_pv = e.valid;
        m_ph = e.hit;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string nm, input exp_t e);
        chk({nm, ".busy"},  32'(busy),       32'(e.busy));
        chk({nm, ".valid"}, 32'(pred_valid), 32'(e.valid));
        chk({nm, ".hit"},   32'(pred_hit),   32'(e.hit));
        chk({nm, ".taken"}, 32'(pred_taken), 32'(e.taken));
        if (e.hit) begin
            chk({nm, ".target"},  pred_target,       e.tgt);
            chk({nm, ".counter"}, 32'(pred_counter), 32'(e.cnt));
        end
`ifdef BTP_STATS_EN
        chk({nm, ".stat_lookups"}, stat_lookups, e.sl);
        chk({nm, ".stat_hits"},    stat_hits,    e.sh);
`else
        chk({nm, ".stat_lookups"}, stat_lookups, 32'd0);
        chk({nm, ".stat_hits"},    stat_hits,    32'd0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        flush_req = 1'b0; lookup_en = 1'b0; lookup_pc = '0; upd_en = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_hit = 1'b0; upd_counter = '0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        model_reset();
    endtask

    // Run idle (optionally probing a lookup) until busy drops; the cycle count is the checked result.
    task automatic count_busy(input string nm, input int expect_n, input bit probe);
        int    n;
        stim_t s;
        exp_t  e;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            s = '0;
            if (probe && n == 5) begin
                s.lk_en = 1'b1;
                s.lk_pc = 32'h0000_1000;
            end
            drive(s, e);
            check_all({nm, ".sweep"}, e);
            if (probe && n == 5) chk({nm, ".lookup_while_busy"}, 32'(pred_valid), 32'd0);
            n++;
        end
        chk({nm, ".busy_cycles"}, n, expect_n);
    endtask

    function automatic vec_t mkv(input logic fl, input logic lk, input logic [31:0] lpc,
                                 input logic ue, input logic [31:0] upc, input logic tk,
                                 input logic [31:0] tgt, input logic uh, input logic [3:0] uc,
                                 input logic ev, input logic eh, input logic et, input logic ctc,
                                 input logic [31:0] etgt, input logic [3:0] ecnt);
        vec_t v;
        v.s.flush = fl; v.s.lk_en = lk; v.s.lk_pc = lpc; v.s.up_en = ue; v.s.up_pc = upc;
        v.s.up_taken = tk; v.s.up_tgt = tgt; v.s.up_hit = uh; v.s.up_cnt = uc;
        v.e_valid = ev; v.e_hit = eh; v.e_taken = et; v.chk_tc = ctc; v.e_tgt = etgt; v.e_cnt = ecnt;
        return v;
    endfunction

    function automatic logic [31:0] rnd_pc();
        logic [31:0] t;
        logic [31:0] ix;
        t  = 32'($urandom_range(0, 2));
        ix = 32'($urandom_range(0, 7));
        return (t << (IDXB + 2)) | (ix << 2) | 32'($urandom_range(0, 3));
    endfunction

    vec_t  vecs [18];
    stim_t s;
    exp_t  e;

    initial begin
        // Directed table (runs after the power-up sweep).
        vecs[0]  = mkv(0, 1, 32'h0000_1000, 0, 0,            0, 0,            0, 0, 1, 0, 0, 0, 0,            0);
        vecs[1]  = mkv(0, 0, 0,             1, 32'h0000_1004, 1, 32'h0000_2000, 0, 0, 0, 0, 0, 0, 0,            0);
        vecs[2]  = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 1, 1, 32'h0000_2000, 2);
        vecs[3]  = mkv(0, 0, 0,             1, 32'h0000_1004, 0, 0,            1, 2, 0, 0, 0, 0, 0,            0);
        vecs[4]  = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 0, 1, 32'h0000_2000, 1);
        vecs[5]  = mkv(0, 0, 0,             1, 32'h0000_1004, 0, 0,            1, 1, 0, 0, 0, 0, 0,            0);
        vecs[6]  = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 0, 1, 32'h0000_2000, 0);
        vecs[7]  = mkv(0, 0, 0,             1, 32'h0000_1004, 1, 32'h0000_2000, 1, 3, 0, 0, 0, 0, 0,            0);
        vecs[8]  = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 1, 1, 32'h0000_2000, 3);
        vecs[9]  = mkv(0, 1, 32'h0040_1004, 0, 0,            0, 0,            0, 0, 1, 0, 0, 0, 0,            0);
        vecs[10] = mkv(0, 1, 32'h0000_3008, 1, 32'h0000_3008, 1, 32'h0000_4440, 0, 0, 1, 1, 1, 1, 32'h0000_4440, 2);
        vecs[11] = mkv(0, 1, 32'h0000_1004, 1, 32'h0000_1004, 1, 32'h0000_5000, 1, 3, 1, 1, 1, 1, 32'h0000_5000, 3);
        vecs[12] = mkv(0, 1, 32'h0000_1004, 1, 32'h0000_1004, 0, 32'h0000_9990, 0, 0, 1, 1, 1, 1, 32'h0000_5000, 3);
        vecs[13] = mkv(0, 0, 0,             1, 32'h0000_1004, 1, 32'h0000_6000, 1, 1, 0, 0, 0, 0, 0,            0);
        vecs[14] = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 1, 1, 32'h0000_6000, 2);
        vecs[15] = mkv(0, 0, 0,             1, 32'h0000_1004, 0, 0,            1, 0, 0, 0, 0, 0, 0,            0);
        vecs[16] = mkv(0, 1, 32'h0000_1004, 0, 0,            0, 0,            0, 0, 1, 1, 0, 1, 32'h0000_6000, 0);
        vecs[17] = mkv(0, 1, 32'h0000_3008, 1, 32'h0000_3008, 0, 32'h0000_7770, 1, 2, 1, 1, 0, 1, 32'h0000_4440, 1);

        // Reset values, then a reset in mid-sweep, then the full power-up sweep.
        do_reset(3);
        chk("reset.busy",         32'(busy),         32'd1);
        chk("reset.pred_valid",   32'(pred_valid),   32'd0);
        chk("reset.pred_hit",     32'(pred_hit),     32'd0);
        chk("reset.pred_taken",   32'(pred_taken),   32'd0);
        chk("reset.pred_target",  pred_target,       32'd0);
        chk("reset.pred_counter", 32'(pred_counter), 32'd0);
        chk("reset.stat_lookups", stat_lookups,      32'd0);
        chk("reset.stat_hits",    stat_hits,         32'd0);
        rst = 1'b1;
        for (int k = 0; k < 300; k++) drive('0, e);
        chk("midsweep.busy", 32'(busy), 32'd1);
        do_reset(2);
        rst = 1'b1;
        count_busy("powerup", NUM, 1'b1);

        // Table-driven vectors.
        for (int k = 0; k < 18; k++) begin
            drive(vecs[k].s, e);
            $display("vec %0d: lk=%0b pc=0x%0h upd=%0b -> valid=%0b hit=%0b taken=%0b tgt=0x%0h cnt=%0d",
                     k, vecs[k].s.lk_en, vecs[k].s.lk_pc, vecs[k].s.up_en,
                     pred_valid, pred_hit, pred_taken, pred_target, pred_counter);
            chk($sformatf("vec%0d.busy", k),  32'(busy),       32'd0);
            chk($sformatf("vec%0d.valid", k), 32'(pred_valid), 32'(vecs[k].e_valid));
            chk($sformatf("vec%0d.hit", k),   32'(pred_hit),   32'(vecs[k].e_hit));
            chk($sformatf("vec%0d.taken", k), 32'(pred_taken), 32'(vecs[k].e_taken));
            if (vecs[k].chk_tc) begin
                chk($sformatf("vec%0d.target", k),  pred_target,       vecs[k].e_tgt);
                chk($sformatf("vec%0d.counter", k), 32'(pred_counter), 32'(vecs[k].e_cnt));
            end
        end

        // Flush from IDLE, restart at sweep index 500, then flush with a colliding update.
        s = '0; s.lk_en = 1'b1; s.lk_pc = 32'h0000_1004;
        drive(s, e);
        check_all("preflush", e);
        s = '0; s.flush = 1'b1;
        drive(s, e);
        chk("flush.busy", 32'(busy), 32'd1);
        chk("flush.stat_lookups", stat_lookups, 32'd0);
        chk("flush.stat_hits",    stat_hits,    32'd0);
        for (int k = 0; k < 500; k++) drive('0, e);
        s = '0; s.flush = 1'b1;
        drive(s, e);
        check_all("restart500", e);
        count_busy("restart500", NUM, 1'b0);
        s = '0; s.flush = 1'b1; s.up_en = 1'b1; s.up_pc = 32'h0000_7000;
        s.up_taken = 1'b1; s.up_tgt = 32'h0000_8000;
        drive(s, e);
        check_all("flush_upd", e);
        count_busy("flush_upd", NUM, 1'b0);
        s = '0; s.lk_en = 1'b1; s.lk_pc = 32'h0000_7000;
        drive(s, e);
        chk("dropped_upd.valid", 32'(pred_valid), 32'd1);
        chk("dropped_upd.hit",   32'(pred_hit),   32'd0);
        s = '0; s.lk_en = 1'b1; s.lk_pc = 32'h0000_1004;
        drive(s, e);
        chk("flushed_entry.hit", 32'(pred_hit), 32'd0);

        // Randomized traffic against the model; WB carries the model's own prediction.
        for (int c = 0; c < 4000; c++) begin
            int ui;
            s = '0;
            s.flush    = ($urandom_range(0, 999) == 0);
            s.lk_en    = ($urandom_range(0, 2) != 0);
            s.lk_pc    = rnd_pc();
            s.up_en    = 1'($urandom_range(0, 1));
            s.up_pc    = rnd_pc();
            s.up_taken = 1'($urandom_range(0, 1));
            s.up_tgt   = $urandom;
            ui = idx_of(s.up_pc);
            s.up_hit = m_valid[ui] && (m_tag[ui] == tag_of(s.up_pc));
            s.up_cnt = s.up_hit ? 4'(m_cnt[ui]) : 4'($urandom_range(0, CMAX));
            drive(s, e);
            check_all($sformatf("rnd%0d", c), e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
